// File: rtl/keynsham_bus_pkg.sv
// Shared types and constants for the keynsham data-bus decoder:
// FSM state encoding, bus widths and the default memory map.
package keynsham_bus_pkg;

  localparam int BUS_ADDR_W = 30;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DEFAULT = 2'd2
  } bus_state_e;

  // Slave 0 occupies the least significant 30-bit field.
  localparam int DEF_NUM_SLAVES = 5;
  localparam logic [DEF_NUM_SLAVES*BUS_ADDR_W-1:0] DEF_SLAVE_BASE = {
    30'h20000000, 30'h20000400, 30'h08000000, 30'h04000000, 30'h00000000
  };
  localparam logic [DEF_NUM_SLAVES*BUS_ADDR_W-1:0] DEF_SLAVE_MASK = {
    30'h3ffffc00, 30'h3ffffc00, 30'h3fe00000, 30'h3ffffc00, 30'h3ffffc00
  };

endpackage

// File: rtl/keynsham_addr_match.sv
// Single address-window comparator: hit when the masked address equals
// the masked base.
module keynsham_addr_match
  import keynsham_bus_pkg::*;
#(
  parameter logic [BUS_ADDR_W-1:0] BASE = '0,
  parameter logic [BUS_ADDR_W-1:0] MASK = '0
) (
  input  logic [BUS_ADDR_W-1:0] addr,
  output logic                  hit
);

  localparam logic [BUS_ADDR_W-1:0] BASE_M = BASE & MASK;

  assign hit = ((addr & MASK) == BASE_M);

endmodule

// File: rtl/keynsham_bus_decoder.sv
// Data-bus interconnect: decodes master accesses onto NUM_SLAVES windows and
// returns ack/data/error. Optional timeout enabled by define BUS_TIMEOUT_EN.
module keynsham_bus_decoder
  import keynsham_bus_pkg::*;
#(
  parameter int                                NUM_SLAVES     = DEF_NUM_SLAVES,
  parameter logic [NUM_SLAVES*BUS_ADDR_W-1:0] SLAVE_BASE     = DEF_SLAVE_BASE,
  parameter logic [NUM_SLAVES*BUS_ADDR_W-1:0] SLAVE_MASK     = DEF_SLAVE_MASK,
  parameter int                                TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             m_access,
  input  logic [BUS_ADDR_W-1:0]            m_addr,
  input  logic                             m_wr_en,
  input  logic [BUS_SEL_W-1:0]             m_bytesel,
  input  logic [BUS_DATA_W-1:0]            m_wr_val,
  output logic [BUS_DATA_W-1:0]            m_data,
  output logic                             m_ack,
  output logic                             m_error,
  output logic [NUM_SLAVES-1:0]            s_access,
  output logic [NUM_SLAVES-1:0]            s_cs,
  output logic [BUS_ADDR_W-1:0]            s_addr,
  output logic                             s_wr_en,
  output logic [BUS_SEL_W-1:0]             s_bytesel,
  output logic [BUS_DATA_W-1:0]            s_wr_val,
  input  logic [BUS_DATA_W*NUM_SLAVES-1:0] s_data,
  input  logic [NUM_SLAVES-1:0]            s_ack,
  input  logic [NUM_SLAVES-1:0]            s_error
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  bus_state_e            r_state;
  bus_state_e            w_state_nxt;
  logic [SEL_W-1:0]      r_sel;
  logic [SEL_W-1:0]      w_sel_nxt;
  logic [SEL_W-1:0]      w_hit_idx;
  logic [NUM_SLAVES-1:0] w_hit;
  logic [NUM_SLAVES-1:0] w_cs;
  logic                  w_hit_any;
  logic                  w_idle;
  logic                  w_sel_ack;
  logic                  w_sel_err;
  logic                  w_timeout;
  logic [BUS_DATA_W-1:0] w_sdata [NUM_SLAVES];

  assign s_addr    = m_addr;
  assign s_wr_en   = m_wr_en;
  assign s_bytesel = m_bytesel;
  assign s_wr_val  = m_wr_val;

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
    keynsham_addr_match #(
      .BASE(SLAVE_BASE[gi*BUS_ADDR_W +: BUS_ADDR_W]),
      .MASK(SLAVE_MASK[gi*BUS_ADDR_W +: BUS_ADDR_W])
    ) u_match (
      .addr(m_addr),
      .hit (w_hit[gi])
    );
    assign w_sdata[gi] = s_data[gi*BUS_DATA_W +: BUS_DATA_W];
  end

  // Lowest matching index wins when windows overlap.
  always_comb begin
    w_cs      = '0;
    w_hit_idx = '0;
    w_hit_any = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (w_hit[i] && !w_hit_any) begin
        w_hit_any = 1'b1;
        w_cs[i]   = 1'b1;
        w_hit_idx = SEL_W'(i);
      end
    end
  end

  assign s_cs      = w_cs;
  assign w_idle    = (r_state == IDLE);
  assign s_access  = w_idle ? (w_cs & {NUM_SLAVES{m_access}}) : '0;
  assign w_sel_ack = s_ack[r_sel];
  assign w_sel_err = s_error[r_sel];

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES));

  // Counts un-acked WAIT cycles and saturates at the limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state != WAIT) begin
      r_cnt <= '0;
    end else if (!w_sel_ack && !w_timeout) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    m_ack       = 1'b0;
    m_error     = 1'b0;
    m_data      = '0;
    case (r_state)
      IDLE: begin
        if (m_access) begin
          if (w_hit_any) begin
            w_state_nxt = WAIT;
            w_sel_nxt   = w_hit_idx;
          end else begin
            w_state_nxt = DEFAULT;
          end
        end
      end
      WAIT: begin
        // A real slave ack in the limit cycle takes precedence over the timeout.
        if (w_sel_ack) begin
          m_ack       = 1'b1;
          m_error     = w_sel_err;
          m_data      = w_sdata[r_sel];
          w_state_nxt = IDLE;
        end else if (w_timeout) begin
          m_ack       = 1'b1;
          m_error     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      DEFAULT: begin
        m_ack       = 1'b1;
        m_error     = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_keynsham_bus_decoder.sv
// Directed-vector bench for keynsham_bus_decoder (default map plus an
// overlapping-window instance).
module tb_keynsham_bus_decoder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         m_access;
  logic [29:0]  m_addr;
  logic         m_wr_en;
  logic [3:0]   m_bytesel;
  logic [31:0]  m_wr_val;
  logic [31:0]  m_data;
  logic         m_ack;
  logic         m_error;
  logic [4:0]   s_access;
  logic [4:0]   s_cs;
  logic [29:0]  s_addr;
  logic         s_wr_en;
  logic [3:0]   s_bytesel;
  logic [31:0]  s_wr_val;
  logic [159:0] s_data;
  logic [4:0]   s_ack;
  logic [4:0]   s_error;

  logic         ov_access;
  logic [31:0]  ov_m_data;
  logic         ov_m_ack;
  logic         ov_m_error;
  logic [3:0]   ov_s_access;
  logic [3:0]   ov_s_cs;
  logic [29:0]  ov_s_addr;
  logic         ov_s_wr_en;
  logic [3:0]   ov_s_bytesel;
  logic [31:0]  ov_s_wr_val;
  logic [127:0] ov_s_data;
  logic [3:0]   ov_s_ack;
  logic [3:0]   ov_s_error;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  keynsham_bus_decoder #(
    .TIMEOUT_CYCLES(8)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_access (m_access),
    .m_addr   (m_addr),
    .m_wr_en  (m_wr_en),
    .m_bytesel(m_bytesel),
    .m_wr_val (m_wr_val),
    .m_data   (m_data),
    .m_ack    (m_ack),
    .m_error  (m_error),
    .s_access (s_access),
    .s_cs     (s_cs),
    .s_addr   (s_addr),
    .s_wr_en  (s_wr_en),
    .s_bytesel(s_bytesel),
    .s_wr_val (s_wr_val),
    .s_data   (s_data),
    .s_ack    (s_ack),
    .s_error  (s_error)
  );

  keynsham_bus_decoder #(
    .NUM_SLAVES(4),
    .SLAVE_BASE({30'h20000400, 30'h00001000, 30'h20000400, 30'h00000000}),
    .SLAVE_MASK({30'h3ffffc00, 30'h3ffffc00, 30'h3ffffc00, 30'h3ffffc00}),
    .TIMEOUT_CYCLES(8)
  ) u_ovl (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_access (ov_access),
    .m_addr   (m_addr),
    .m_wr_en  (m_wr_en),
    .m_bytesel(m_bytesel),
    .m_wr_val (m_wr_val),
    .m_data   (ov_m_data),
    .m_ack    (ov_m_ack),
    .m_error  (ov_m_error),
    .s_access (ov_s_access),
    .s_cs     (ov_s_cs),
    .s_addr   (ov_s_addr),
    .s_wr_en  (ov_s_wr_en),
    .s_bytesel(ov_s_bytesel),
    .s_wr_val (ov_s_wr_val),
    .s_data   (ov_s_data),
    .s_ack    (ov_s_ack),
    .s_error  (ov_s_error)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_resp(input string tag, input logic ack, input logic err, input logic [31:0] data);
    check_vec({tag, "_ack"}, {31'd0, m_ack}, {31'd0, ack});
    check_vec({tag, "_err"}, {31'd0, m_error}, {31'd0, err});
    check_vec({tag, "_data"}, m_data, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int lat;
    logic lat_err;
    logic [31:0] lat_data;

    rst_n     = 1'b0;
    m_access  = 1'b0;
    m_addr    = '0;
    m_wr_en   = 1'b0;
    m_bytesel = 4'h0;
    m_wr_val  = '0;
    s_data    = '0;
    s_ack     = '0;
    s_error   = '0;
    ov_access = 1'b0;
    ov_s_data = '0;
    ov_s_ack  = '0;
    ov_s_error = '0;

    // Reset state
    tick(); tick();
    sample();
    check_resp("reset", 1'b0, 1'b0, 32'h0);
    check_vec("reset_s_access", {27'd0, s_access}, 32'h0);
    tick();
    rst_n = 1'b1;

    // Read slave 0, ack next cycle, then back-to-back second read
    m_access = 1'b1; m_addr = 30'h00000010; m_wr_en = 1'b0; m_bytesel = 4'hf;
    sample();
    check_vec("rd0_s_access", {27'd0, s_access}, 32'h01);
    check_vec("rd0_s_cs", {27'd0, s_cs}, 32'h01);
    check_resp("rd0_idle", 1'b0, 1'b0, 32'h0);
    tick();
    m_access = 1'b0; s_ack[0] = 1'b1; s_data[31:0] = 32'hdeadbeef;
    sample();
    check_resp("rd0_done", 1'b1, 1'b0, 32'hdeadbeef);
    check_vec("rd0_no_reaccess", {27'd0, s_access}, 32'h0);
    tick();
    s_ack[0] = 1'b0;
    m_access = 1'b1; m_addr = 30'h000003fc;
    sample();
    check_vec("b2b_s_access", {27'd0, s_access}, 32'h01);
    check_resp("b2b_idle", 1'b0, 1'b0, 32'h0);
    tick();
    m_access = 1'b0; s_ack[0] = 1'b1; s_data[31:0] = 32'h00c0ffee;
    sample();
    check_resp("b2b_done", 1'b1, 1'b0, 32'h00c0ffee);
    tick();
    s_ack[0] = 1'b0;

    // Unmapped access
    m_access = 1'b1; m_addr = 30'h30000000;
    sample();
    check_vec("unmap_s_access", {27'd0, s_access}, 32'h0);
    check_vec("unmap_s_cs", {27'd0, s_cs}, 32'h0);
    tick();
    m_access = 1'b0;
    sample();
    check_resp("unmap_resp", 1'b1, 1'b1, 32'h0);
    tick();
    sample();
    check_resp("unmap_after", 1'b0, 1'b0, 32'h0);

    // Window decode and pass-through on the default map
    m_addr = 30'h20000400;
    sample();
    check_vec("dec_slave3", {27'd0, s_cs}, 32'h08);
    check_vec("ovl_cs", {28'd0, ov_s_cs}, 32'h2);
    m_addr = 30'h20000000;
    #1;
    check_vec("dec_slave4", {27'd0, s_cs}, 32'h10);
    m_addr = 30'h041003ff;
    #1;
    check_vec("dec_outside1", {27'd0, s_cs}, 32'h0);
    tick();

    // Write to slave 2 which never acks
    m_access = 1'b1; m_addr = 30'h081fff00; m_wr_en = 1'b1;
    m_bytesel = 4'h5; m_wr_val = 32'ha5a5_1234;
    sample();
    check_vec("wr2_s_access", {27'd0, s_access}, 32'h04);
    check_vec("wr2_s_addr", {2'd0, s_addr}, 32'h081fff00);
    check_vec("wr2_s_ctl", {27'd0, s_wr_en, s_bytesel}, 32'h15);
    check_vec("wr2_s_wr_val", s_wr_val, 32'ha5a51234);
    tick();
    m_access = 1'b0; m_wr_en = 1'b0;
    lat = 0; lat_err = 1'b0; lat_data = 32'h0;
    for (int k = 1; k <= 20; k++) begin
      sample();
      if (m_ack && lat == 0) begin
        lat = k; lat_err = m_error; lat_data = m_data;
      end
      tick();
    end
`ifdef BUS_TIMEOUT_EN
    check_vec("tmo_latency", lat, 32'd9);
    check_vec("tmo_err", {31'd0, lat_err}, 32'h1);
    check_vec("tmo_data", lat_data, 32'h0);
`else
    check_vec("hold_no_ack", lat, 32'd0);
    s_ack[2] = 1'b1; s_data[95:64] = 32'h5555aaaa;
    sample();
    check_resp("hold_ack", 1'b1, 1'b0, 32'h5555aaaa);
    tick();
    s_ack[2] = 1'b0;
`endif

    // Following access to slave 0 completes normally
    m_access = 1'b1; m_addr = 30'h00000020;
    sample();
    check_vec("post_s_access", {27'd0, s_access}, 32'h01);
    tick();
    m_access = 1'b0; s_ack[0] = 1'b1; s_data[31:0] = 32'h13579bdf;
    sample();
    check_resp("post_done", 1'b1, 1'b0, 32'h13579bdf);
    tick();
    s_ack[0] = 1'b0;

`ifdef BUS_TIMEOUT_EN
    // Slave ack in the timeout cycle wins
    m_access = 1'b1; m_addr = 30'h08000004;
    tick();
    m_access = 1'b0;
    for (int k = 1; k < 9; k++) begin
      sample();
      check_vec("race_pending", {31'd0, m_ack}, 32'h0);
      tick();
    end
    s_ack[2] = 1'b1; s_data[95:64] = 32'h12345678;
    sample();
    check_resp("race_ack", 1'b1, 1'b0, 32'h12345678);
    tick();
    s_ack[2] = 1'b0;
`endif

    // Spurious ack from slave 3, error without ack, access during WAIT
    m_access = 1'b1; m_addr = 30'h00000100;
    tick();
    m_access = 1'b1; m_addr = 30'h00000104;
    s_ack[3] = 1'b1; s_error[3] = 1'b1; s_data[127:96] = 32'hcafef00d;
    s_error[0] = 1'b1;
    sample();
    check_resp("spur_ignored", 1'b0, 1'b0, 32'h0);
    check_vec("spur_no_access", {27'd0, s_access}, 32'h0);
    tick();
    m_access = 1'b0;
    s_ack[3] = 1'b0; s_error[3] = 1'b0; s_error[0] = 1'b0;
    s_ack[0] = 1'b1; s_data[31:0] = 32'h0badf00d;
    sample();
    check_resp("spur_sel_ack", 1'b1, 1'b0, 32'h0badf00d);
    tick();
    s_ack[0] = 1'b0;

    // Slave error with ack
    m_access = 1'b1; m_addr = 30'h04000008;
    tick();
    m_access = 1'b0; s_ack[1] = 1'b1; s_error[1] = 1'b1; s_data[63:32] = 32'h00000bad;
    sample();
    check_resp("s1_err", 1'b1, 1'b1, 32'h00000bad);
    tick();
    s_ack[1] = 1'b0; s_error[1] = 1'b0;

    // Reset during WAIT abandons the transaction
    m_access = 1'b1; m_addr = 30'h04000020;
    tick();
    m_access = 1'b0; rst_n = 1'b0;
    sample();
    check_resp("rst_wait", 1'b0, 1'b0, 32'h0);
    tick();
    rst_n = 1'b1; s_ack[1] = 1'b1; s_data[63:32] = 32'hfeedface;
    sample();
    check_resp("rst_late_ack", 1'b0, 1'b0, 32'h0);
    tick();
    s_ack[1] = 1'b0;
    m_access = 1'b1; m_addr = 30'h04000024;
    sample();
    check_vec("rst_next_access", {27'd0, s_access}, 32'h02);
    tick();
    m_access = 1'b0; s_ack[1] = 1'b1; s_data[63:32] = 32'h2468ace0;
    sample();
    check_resp("rst_next_done", 1'b1, 1'b0, 32'h2468ace0);
    tick();
    s_ack[1] = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
